// File: rtl/store_buffer.sv
// Write-posting store buffer between the core's data port and a memory that can refuse writes.
// Stores drain in program order; loads see the youngest buffered store to the same word.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_a,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  output logic [31:0] mem_ra,
  input  logic [31:0] mem_rd,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic        mem_wready,
  output logic        busy
);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count;
  logic               full, empty, push, pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // A pop in the same cycle does not free a slot for a full-buffer push.
  assign push      = cpu_we && !full;
  assign pop       = mem_we && mem_wready;

  assign cpu_stall = cpu_we && full;
  assign mem_ra    = cpu_a;
  assign mem_we    = !empty;
  assign busy      = !empty;
  assign mem_wa    = {ent[head].addr, 2'b00};
  assign mem_wd    = ent[head].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; validity comes only from head/count.
  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{addr: cpu_a[31:2], data: cpu_wd};
  end

  // Walk oldest to youngest so the last match is the youngest store.
  always_comb begin
    cpu_rd = mem_rd;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && (ent[head + PTR_W'(i)].addr == cpu_a[31:2]))
        cpu_rd = ent[head + PTR_W'(i)].data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, checked against a queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_a, cpu_wd, cpu_rd, mem_ra, mem_rd, mem_wa, mem_wd;
  logic        cpu_we, cpu_stall, mem_we, mem_wready, busy;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_we(cpu_we), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall), .mem_ra(mem_ra), .mem_rd(mem_rd),
    .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_we(mem_we), .mem_wready(mem_wready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } st_t;

  st_t         q[$];
  logic [31:0] wlog[$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One CPU cycle: drive, check combinational outputs mid-cycle, then advance model at the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic wr, input logic [31:0] mrd);
    logic [31:0] exp_rd;
    logic        do_pop, do_push;
    cpu_we = we; cpu_a = a; cpu_wd = wd; mem_wready = wr; mem_rd = mrd;
    @(negedge clk);
    exp_rd = mrd;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a[31:2]) begin exp_rd = q[i].d; break; end
    chk("busy",   {31'b0, busy},      {31'b0, q.size() != 0});
    chk("mem_we", {31'b0, mem_we},    {31'b0, q.size() != 0});
    chk("stall",  {31'b0, cpu_stall}, {31'b0, we && q.size() == DEPTH});
    chk("mem_ra", mem_ra, a);
    chk("cpu_rd", cpu_rd, exp_rd);
    if (q.size() != 0) begin
      chk("mem_wa", mem_wa, {q[0].a, 2'b00});
      chk("mem_wd", mem_wd, q[0].d);
    end
    do_pop  = wr && q.size() != 0;
    do_push = we && q.size() < DEPTH;
    @(posedge clk);
    if (do_pop) begin
      wlog.push_back(q[0].d);
      void'(q.pop_front());
    end
    if (do_push) q.push_back('{a: a[31:2], d: wd});
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_we = 0; cpu_a = 0; cpu_wd = 0; mem_wready = 0; mem_rd = 32'h1234_5678;
    #12;
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'h1234_5678);
    reset = 1'b0;
    @(posedge clk); #1;

    // Idle after reset, loads pass through.
    for (int i = 0; i < 3; i++) cyc(0, $urandom & 32'hFC, 0, 1, $urandom);

    // Single store drains next cycle.
    cyc(1, 32'h10, 32'h11, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Fill with memory refusing, fifth store stalls, then drain and retry.
    for (int i = 0; i < 5; i++) cyc(1, 32'(i * 4), 32'(100 + i), 0, 0);
    cyc(1, 32'h10, 32'd104, 0, 0);
    cyc(1, 32'h10, 32'd104, 1, 0);
    cyc(1, 32'h10, 32'd104, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    chk("drain_order0", wlog[wlog.size()-5], 32'd100);
    chk("drain_order4", wlog[wlog.size()-1], 32'd104);

    // Forwarding picks the youngest of duplicate addresses.
    cyc(1, 32'h20, 32'hA, 0, 0);
    cyc(1, 32'h20, 32'hB, 0, 0);
    cyc(0, 32'h20, 0, 0, 32'hDEAD);
    chk("fwd_young", cpu_rd, 32'hB);
    cyc(0, 32'h24, 0, 0, 32'hDEAD);
    for (int i = 0; i < 3; i++) cyc(0, 32'h20, 0, 1, 32'hDEAD);
    chk("dup_first",  wlog[wlog.size()-2], 32'hA);
    chk("dup_second", wlog[wlog.size()-1], 32'hB);

    // Full buffer with continuous stores and drains: wraps pointers.
    for (int i = 0; i < 4; i++) cyc(1, 32'(32'h40 + i * 4), 32'(200 + i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'(32'h80 + i * 4), 32'(300 + i), 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle with pending stores.
    for (int i = 0; i < 3; i++) cyc(1, 32'(32'hC0 + i * 4), 32'(400 + i), 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("arst_busy",   {31'b0, busy},   32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 32'hC0, 0, 1, 32'h5555);

    // Random traffic over a small address window to stress forwarding.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 55), {26'b0, 4'($urandom), 2'b00}, $urandom,
          ($urandom_range(0, 99) < 50), $urandom);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    chk("final_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
